// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 keypad row scan, debounce and key strobe FSM
//
// Purpose: drives the keypad rows active-low one at a time, samples the
// already-synchronized columns, freezes on a pressed row, debounces the
// press, emits a one-cycle key strobe with the hex code, then waits for a
// debounced release before scanning resumes.
//
// Ports:
//   clk        in   1  system clock
//   reset      in   1  asynchronous, active-high reset
//   cols_sync  in   4  synchronized columns, active-low, bit i = column i
//   rows       out  4  row drive, active-low, exactly one bit low
//   key_code   out  4  hex code of the last accepted key
//   key_valid  out  1  one-cycle strobe when a key is accepted
//   key_held   out  1  high from key_valid until the debounced release
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols_sync,
  output logic [3:0] rows,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_CNT = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HOLD,
    S_RELEASE
  } state_e;

  state_e          state_q;
  logic [1:0]      row_idx_q;
  logic [CW-1:0]   cnt_q;
  logic [3:0]      col_cap_q;
  logic [3:0]      key_code_q;
  logic            key_valid_q;
  logic            key_held_q;

  logic            single_low_d;
  logic [1:0]      col_idx_d;
  logic [3:0]      code_d;

  // Decode the captured columns: a valid key has exactly one low bit.
  always_comb begin
    single_low_d = 1'b1;
    col_idx_d    = 2'd0;
    case (col_cap_q)
      4'b1110: col_idx_d = 2'd0;
      4'b1101: col_idx_d = 2'd1;
      4'b1011: col_idx_d = 2'd2;
      4'b0111: col_idx_d = 2'd3;
      default: single_low_d = 1'b0;
    endcase
  end

  // Keypad legend, indexed by {row, column}.
  always_comb begin
    code_d = 4'h0;
    case ({row_idx_q, col_idx_d})
      4'b00_00: code_d = 4'h1;
      4'b00_01: code_d = 4'h2;
      4'b00_10: code_d = 4'h3;
      4'b00_11: code_d = 4'hA;
      4'b01_00: code_d = 4'h4;
      4'b01_01: code_d = 4'h5;
      4'b01_10: code_d = 4'h6;
      4'b01_11: code_d = 4'hB;
      4'b10_00: code_d = 4'h7;
      4'b10_01: code_d = 4'h8;
      4'b10_10: code_d = 4'h9;
      4'b10_11: code_d = 4'hC;
      4'b11_00: code_d = 4'hE;
      4'b11_01: code_d = 4'h0;
      4'b11_10: code_d = 4'hF;
      default:  code_d = 4'hD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SCAN;
      row_idx_q   <= 2'd0;
      cnt_q       <= '0;
      col_cap_q   <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      case (state_q)
        S_SCAN: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q <= '0;
            if (cols_sync == 4'hF) begin
              row_idx_q <= row_idx_q + 2'd1;
            end else begin
              // Row stays driven so the debounce watches the same contact.
              col_cap_q <= cols_sync;
              state_q   <= S_DEBOUNCE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DEBOUNCE: begin
          if (cols_sync != col_cap_q) begin
            cnt_q     <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            state_q   <= S_SCAN;
          end else if (cnt_q == DB_LAST) begin
            cnt_q <= '0;
            if (single_low_d) begin
              key_valid_q <= 1'b1;
              key_code_q  <= code_d;
              key_held_q  <= 1'b1;
              state_q     <= S_HOLD;
            end else begin
              // Multi-key chord on one row is ignored.
              row_idx_q <= row_idx_q + 2'd1;
              state_q   <= S_SCAN;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_HOLD: begin
          cnt_q <= '0;
          if (cols_sync == 4'hF) begin
            state_q <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (cols_sync != 4'hF) begin
            // Bounce during release: keep holding, no repeat strobe.
            cnt_q   <= '0;
            state_q <= S_HOLD;
          end else if (cnt_q == DB_LAST) begin
            cnt_q      <= '0;
            key_held_q <= 1'b0;
            row_idx_q  <= row_idx_q + 2'd1;
            state_q    <= S_SCAN;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_SCAN;
        end
      endcase
    end
  end

  assign rows      = ~(4'b0001 << row_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols_sync;
  logic [3:0] rows;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_code;

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cols_sync(cols_sync),
    .rows     (rows),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected key.
  always @(negedge clk) begin
    if (reset === 1'b0 && key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got key_code %h want no strobe", key_code);
      end else begin
        exp_code = sb.pop_front();
        check("strobe_code", key_code, exp_code);
        check("strobe_held", {3'b000, key_held}, 4'h1);
      end
    end
  end

  // Returns at the first negedge of a fresh scan window of row pattern r.
  task automatic wait_row_start(input logic [3:0] r);
    int n;
    n = 0;
    while (rows === r && n < 40) begin
      @(negedge clk);
      n++;
    end
    while (rows !== r && n < 80) begin
      @(negedge clk);
      n++;
    end
    check("row_start", rows, r);
  endtask

  task automatic wait_held(input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (key_held !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {3'b000, key_held}, {3'b000, v});
  endtask

  task automatic press_key(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code);
    wait_row_start(r);
    cols_sync = c;
    sb.push_back(code);
    wait_held(1'b1, 40, "press_held");
    check("press_row_frozen", rows, r);
    cols_sync = 4'hF;
    wait_held(1'b0, 20, "press_released");
    check("press_next_row", rows, {r[2:0], r[3]});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rows"}, rows, 4'b1110);
    check({tag, "_code"}, key_code, 4'h0);
    check({tag, "_valid"}, {3'b000, key_valid}, 4'h0);
    check({tag, "_held"}, {3'b000, key_held}, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    cols_sync = 4'hF;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    // Idle scan timing.
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("scan_row1", rows, 4'b1101);
    repeat (12) @(negedge clk);
    check("scan_wrap", rows, 4'b1110);
    check("scan_no_strobe", {3'b000, key_valid}, 4'h0);

    // Key 6 on row 1, column 2.
    wait_row_start(4'b1101);
    cols_sync = 4'b1011;
    sb.push_back(4'h6);
    wait_held(1'b1, 40, "t2_held");
    check("t2_rows", rows, 4'b1101);
    repeat (3) @(negedge clk);
    check("t2_rows_hold", rows, 4'b1101);
    check("t2_code_hold", key_code, 4'h6);

    // Short release, bounce back, then full release.
    cols_sync = 4'hF;
    repeat (5) @(negedge clk);
    check("t5_held_short_rel", {3'b000, key_held}, 4'h1);
    cols_sync = 4'b1011;
    repeat (3) @(negedge clk);
    check("t5_held_repress", {3'b000, key_held}, 4'h1);
    cols_sync = 4'hF;
    repeat (7) @(negedge clk);
    check("t5_held_mid_rel", {3'b000, key_held}, 4'h1);
    wait_held(1'b0, 10, "t5_release_done");
    check("t5_resume_row2", rows, 4'b1011);

    // Press that bounces after 3 debounce cycles.
    wait_row_start(4'b1101);
    cols_sync = 4'b1110;
    repeat (7) @(negedge clk);
    check("t3_frozen", rows, 4'b1101);
    cols_sync = 4'hF;
    @(negedge clk);
    check("t3_next_row", rows, 4'b1011);
    check("t3_held", {3'b000, key_held}, 4'h0);

    // Two keys on row 0.
    wait_row_start(4'b1110);
    cols_sync = 4'b1001;
    repeat (11) @(negedge clk);
    check("t4_frozen", rows, 4'b1110);
    @(negedge clk);
    check("t4_advance", rows, 4'b1101);
    cols_sync = 4'hF;
    check("t4_code_kept", key_code, 4'h6);
    check("t4_held", {3'b000, key_held}, 4'h0);

    // Map corners.
    press_key(4'b1110, 4'b1101, 4'h2);
    press_key(4'b0111, 4'b1110, 4'hE);
    press_key(4'b1011, 4'b0111, 4'hC);
    press_key(4'b0111, 4'b1101, 4'h0);
    press_key(4'b1110, 4'b0111, 4'hA);
    press_key(4'b0111, 4'b1011, 4'hF);

    // Reset while HOLD.
    wait_row_start(4'b1011);
    cols_sync = 4'b1110;
    sb.push_back(4'h7);
    wait_held(1'b1, 40, "t6_hold_held");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_hold_rst");
    cols_sync = 4'hF;
    @(negedge clk);
    reset = 1'b0;

    // Reset while DEBOUNCE.
    cols_sync = 4'b0111;
    repeat (7) @(negedge clk);
    check("t6_db_frozen", rows, 4'b1110);
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_db_rst");
    @(negedge clk);
    reset     = 1'b0;
    cols_sync = 4'hF;
    repeat (30) @(negedge clk);
    check("t6_code_after", key_code, 4'h0);
    check("t6_held_after", {3'b000, key_held}, 4'h0);

    check("sb_empty", 4'(sb.size()), 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
